// File: rtl/cpu_timing_gen_pkg.sv
// Shared defaults and types for the CPU timing generator.
package cpu_timing_gen_pkg;

    localparam int DEF_DIV_STAGES       = 4;
    localparam int DEF_NPHASE           = 8;
    localparam int DEF_LATCH_PHASE      = 5;
    localparam int DEF_LATCH_MASK_PHASE = 1;

    // Wide enough to name any of up to 16 phase strobes.
    localparam int PHASE_IDX_W = 4;
    typedef logic [PHASE_IDX_W-1:0] phase_idx_t;

endpackage

// File: rtl/cpu_timing_phase_chain.sv
// Phase strobe delay line: tap k is the input delayed by k+1 cycles, frozen while hold is high.
module cpu_timing_phase_chain
    import cpu_timing_gen_pkg::*;
#(
    parameter int NPHASE = DEF_NPHASE
) (
    input  logic              clk32,
    input  logic              resb,
    input  logic              clear,
    input  logic              hold,
    input  logic              din,
    output logic [NPHASE-1:0] taps
);

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            taps <= '0;
        end else if (clear) begin
            taps <= '0;
        end else if (!hold) begin
            taps <= {taps[NPHASE-2:0], din};
        end
    end

endmodule

// File: rtl/cpu_timing_gen.sv
// CPU timing generator: binary divider, clock enables, phase strobes and latch window.
// Bus-cycle stretching via stall_i is compiled in only when CPU_TIMING_GEN_STRETCH_EN is defined.
module cpu_timing_gen
    import cpu_timing_gen_pkg::*;
#(
    parameter int DIV_STAGES       = DEF_DIV_STAGES,
    parameter int NPHASE           = DEF_NPHASE,
    parameter int LATCH_PHASE      = DEF_LATCH_PHASE,
    parameter int LATCH_MASK_PHASE = DEF_LATCH_MASK_PHASE
) (
    input  logic                  clk32,
    input  logic                  resb,
    input  logic                  sync_i,
    input  logic                  stall_i,
    output logic [DIV_STAGES-1:0] clk_o,
    output logic [DIV_STAGES-1:0] en_o,
    output logic [NPHASE-1:0]     time_o,
    output logic                  latch_o
);

    localparam phase_idx_t LATCH_TAP = phase_idx_t'(LATCH_PHASE);
    localparam phase_idx_t MASK_TAP  = phase_idx_t'(LATCH_MASK_PHASE);

    logic [DIV_STAGES-1:0] cnt;
    logic [DIV_STAGES-1:0] en_next;
    logic                  hold;

`ifdef CPU_TIMING_GEN_STRETCH_EN
    assign hold = stall_i;
`else
    // stall_i stays on the pin list for drop-in compatibility but never freezes the sequencer.
    assign hold = stall_i & 1'b0;
`endif

    for (genvar i = 0; i < DIV_STAGES; i++) begin : g_en
        assign en_next[i] = &cnt[i:0];
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            cnt     <= '0;
            en_o    <= '0;
            latch_o <= 1'b0;
        end else if (sync_i) begin
            cnt     <= '0;
            en_o    <= '0;
            latch_o <= 1'b0;
        end else if (hold) begin
            en_o    <= '0;
        end else begin
            cnt     <= cnt + DIV_STAGES'(1);
            en_o    <= en_next;
            latch_o <= time_o[int'(LATCH_TAP)] & ~time_o[int'(MASK_TAP)];
        end
    end

    assign clk_o = cnt;

    cpu_timing_phase_chain #(
        .NPHASE (NPHASE)
    ) u_phase_chain (
        .clk32 (clk32),
        .resb  (resb),
        .clear (sync_i),
        .hold  (hold),
        .din   (cnt[DIV_STAGES-1]),
        .taps  (time_o)
    );

endmodule

// File: tb/tb_cpu_timing_gen.sv
// Self-checking bench for cpu_timing_gen at default parameters; stall expectations follow CPU_TIMING_GEN_STRETCH_EN.
module tb_cpu_timing_gen;

    logic       clk32 = 1'b0;
    logic       resb;
    logic       sync_i;
    logic       stall_i;
    logic [3:0] clk_o;
    logic [3:0] en_o;
    logic [7:0] time_o;
    logic       latch_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         n;
        logic [3:0] cnt;
        logic [3:0] en;
        logic [7:0] tim;
        logic       latch;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    // Free-run states 23..28, used when stall_i is ignored.
    vec_t free_after [6];

    always #5 clk32 = ~clk32;

    cpu_timing_gen dut (
        .clk32   (clk32),
        .resb    (resb),
        .sync_i  (sync_i),
        .stall_i (stall_i),
        .clk_o   (clk_o),
        .en_o    (en_o),
        .time_o  (time_o),
        .latch_o (latch_o)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] c, input logic [3:0] e,
                           input logic [7:0] t, input logic l);
        chk({tag, " clk_o"},   {4'h0, clk_o},   {4'h0, c});
        chk({tag, " en_o"},    {4'h0, en_o},    {4'h0, e});
        chk({tag, " time_o"},  time_o,          t);
        chk({tag, " latch_o"}, {7'h0, latch_o}, {7'h0, l});
    endtask

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    initial begin
        int vi;
        int en0_cnt;
        int en3_cnt;

        vecs[0]  = '{1,  4'h1, 4'b0000, 8'h00, 1'b0};
        vecs[1]  = '{2,  4'h2, 4'b0001, 8'h00, 1'b0};
        vecs[2]  = '{4,  4'h4, 4'b0011, 8'h00, 1'b0};
        vecs[3]  = '{8,  4'h8, 4'b0111, 8'h00, 1'b0};
        vecs[4]  = '{9,  4'h9, 4'b0000, 8'h01, 1'b0};
        vecs[5]  = '{12, 4'hC, 4'b0011, 8'h0F, 1'b0};
        vecs[6]  = '{16, 4'h0, 4'b1111, 8'hFF, 1'b0};
        vecs[7]  = '{17, 4'h1, 4'b0000, 8'hFE, 1'b0};
        vecs[8]  = '{19, 4'h3, 4'b0000, 8'hF8, 1'b1};
        vecs[9]  = '{22, 4'h6, 4'b0001, 8'hC0, 1'b1};
        vecs[10] = '{23, 4'h7, 4'b0000, 8'h80, 1'b0};
        vecs[11] = '{35, 4'h3, 4'b0000, 8'hF8, 1'b1};
        vecs[12] = '{64, 4'h0, 4'b1111, 8'hFF, 1'b0};

        free_after[0] = '{23, 4'h7, 4'b0000, 8'h80, 1'b0};
        free_after[1] = '{24, 4'h8, 4'b0111, 8'h00, 1'b0};
        free_after[2] = '{25, 4'h9, 4'b0000, 8'h01, 1'b0};
        free_after[3] = '{26, 4'hA, 4'b0001, 8'h03, 1'b0};
        free_after[4] = '{27, 4'hB, 4'b0000, 8'h07, 1'b0};
        free_after[5] = '{28, 4'hC, 4'b0011, 8'h0F, 1'b0};

        resb    = 1'b0;
        sync_i  = 1'b0;
        stall_i = 1'b0;
        #1;
        chk_all("reset", 4'h0, 4'h0, 8'h00, 1'b0);
        step();
        step();
        chk_all("reset held", 4'h0, 4'h0, 8'h00, 1'b0);
        resb = 1'b1;

        // Free run over four full divider periods.
        vi = 0;
        en0_cnt = 0;
        en3_cnt = 0;
        for (int n = 1; n <= 64; n++) begin
            step();
            chk($sformatf("n=%0d clk_o seq", n), {4'h0, clk_o}, 8'(n % 16));
            if (en_o[0]) en0_cnt++;
            if (en_o[3]) begin
                en3_cnt++;
                chk($sformatf("n=%0d en3 position", n), {4'h0, clk_o}, 8'h00);
            end
            if (vi < NVEC && vecs[vi].n == n) begin
                chk_all($sformatf("n=%0d", n), vecs[vi].cnt, vecs[vi].en, vecs[vi].tim, vecs[vi].latch);
                vi++;
            end
        end
        chk("en0 pulse count", 8'(en0_cnt), 8'd32);
        chk("en3 pulse count", 8'(en3_cnt), 8'd4);

        // Sync with stall asserted at cnt=11: sync wins and clears everything.
        for (int i = 0; i < 11; i++) step();
        chk_all("pre-sync", 4'hB, 4'h0, 8'h07, 1'b0);
        sync_i  = 1'b1;
        stall_i = 1'b1;
        step();
        sync_i  = 1'b0;
        stall_i = 1'b0;
        chk_all("sync", 4'h0, 4'h0, 8'h00, 1'b0);
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n == 1) chk_all("post-sync n=1", 4'h1, 4'h0, 8'h00, 1'b0);
            if (n == 9) chk_all("post-sync n=9", 4'h9, 4'h0, 8'h01, 1'b0);
        end
        chk_all("pre-stall", 4'h6, 4'b0001, 8'hC0, 1'b1);

        // Five stalled cycles at cnt=6, then release.
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
`ifdef CPU_TIMING_GEN_STRETCH_EN
            chk_all($sformatf("stall %0d", i), 4'h6, 4'h0, 8'hC0, 1'b1);
`else
            chk_all($sformatf("stall ignored %0d", i), free_after[i].cnt, free_after[i].en,
                    free_after[i].tim, free_after[i].latch);
`endif
        end
        stall_i = 1'b0;
        step();
`ifdef CPU_TIMING_GEN_STRETCH_EN
        chk_all("stall release", 4'h7, 4'h0, 8'h80, 1'b0);
        step();
        chk_all("stall release+1", 4'h8, 4'b0111, 8'h00, 1'b0);
`else
        chk_all("stall ignored 5", free_after[5].cnt, free_after[5].en,
                free_after[5].tim, free_after[5].latch);
`endif

        // Asynchronous reset mid-cycle at cnt=13, then timing replays from scratch.
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        for (int i = 0; i < 13; i++) step();
        chk_all("pre-reset", 4'hD, 4'h0, 8'h1F, 1'b0);
        #2;
        resb = 1'b0;
        #1;
        chk_all("async reset", 4'h0, 4'h0, 8'h00, 1'b0);
        step();
        chk_all("async reset held", 4'h0, 4'h0, 8'h00, 1'b0);
        #3;
        resb = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            step();
            if (n == 8)  chk_all("rerun n=8",  4'h8, 4'b0111, 8'h00, 1'b0);
            if (n == 9)  chk_all("rerun n=9",  4'h9, 4'b0000, 8'h01, 1'b0);
            if (n == 16) chk_all("rerun n=16", 4'h0, 4'b1111, 8'hFF, 1'b0);
            if (n == 19) chk_all("rerun n=19", 4'h3, 4'b0000, 8'hF8, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_timing_gen.md
CPU_TIMING_GEN -- requirements
Module: cpu_timing_gen

Interface
REQ-001 Parameter DIV_STAGES, default 4, SHALL set the number of binary divider stages below clk32.
REQ-002 Parameter NPHASE, default 8, SHALL set the number of phase strobes time_o[NPHASE-1:0]; legal range 2..16.
REQ-003 Parameter LATCH_PHASE, default 5, SHALL select the phase that opens the latch window; legal range 1..NPHASE-1.
REQ-004 Parameter LATCH_MASK_PHASE, default 1, SHALL select the phase that masks the latch window; it SHALL be less than LATCH_PHASE.
REQ-005 clk32  input  1  sole clock; all state changes on its rising edge.
REQ-006 resb  input  1  reset, asynchronous assert, active-low.
REQ-007 sync_i  input  1  synchronous resequence request.
REQ-008 stall_i  input  1  bus-cycle stretch request.
REQ-009 clk_o  output  DIV_STAGES  divided clocks; clk_o[i] has period 2^(i+1) clk32 cycles.
REQ-010 en_o  output  DIV_STAGES  one-cycle clock enables, one per divided clock.
REQ-011 time_o  output  NPHASE  phase strobes.
REQ-012 latch_o  output  1  active-high latch strobe.

Function
REQ-013 Divider counter cnt, DIV_STAGES wide, SHALL increment by 1 each unstalled cycle and wrap from all-ones to 0; clk_o SHALL equal cnt.
REQ-014 en_o[i] SHALL be a registered copy of (cnt[i:0] all-ones), i.e. high for exactly one cycle per 2^(i+1) unstalled cycles, in the first cycle of clk_o[i] low.
REQ-015 time_o[0] SHALL be cnt[DIV_STAGES-1] registered one cycle; time_o[k] SHALL be time_o[k-1] registered one cycle, so time_o[k] lags time_o[0] by k cycles.
REQ-016 latch_o SHALL be registered (time_o[LATCH_PHASE] & ~time_o[LATCH_MASK_PHASE]).
REQ-017 sync_i high at a rising edge SHALL load every register with its reset value at that edge; sync_i has priority over stall_i.
REQ-018 Stall (see Configuration) SHALL hold cnt, clk_o, time_o and latch_o unchanged and force en_o to 0 for every cycle stall_i is sampled high.
REQ-019 Release of stall SHALL resume counting from the held value with no lost or duplicated count.
REQ-020 Sequence is free-running; no terminal state other than wrap.

Reset
REQ-021 resb low SHALL immediately force cnt=0, clk_o=0, en_o=0, time_o=0, latch_o=0, independent of clk32.
REQ-022 resb deassertion mid-sequence SHALL restart from cnt=0 at the first rising edge after release; no partial phases retained.

Configuration
REQ-023 Macro CPU_TIMING_GEN_STRETCH_EN defined: stall_i SHALL behave per REQ-018/019.
REQ-024 Macro CPU_TIMING_GEN_STRETCH_EN undefined: stall_i SHALL be ignored, port retained, sequencer SHALL never freeze.

Structure
REQ-025 Package cpu_timing_gen_pkg SHALL hold default parameter constants (DIV_STAGES, NPHASE, LATCH_PHASE, LATCH_MASK_PHASE) and the phase-index type.
REQ-026 Sub-module cpu_timing_phase_chain SHALL implement the NPHASE delay line with hold input; counter, enables and latch stay in the top.

Verification (defaults; edge n = nth clk32 rising edge after resb release)
REQ-027 Free-run 64 cycles -> clk_o[3] period 16; en_o[3] high only after edges 16,32,48,64; en_o[0] high every 2nd cycle.
REQ-028 Free-run -> time_o[0] first high after edge 9 for 8 cycles; time_o[k] identical shape delayed k cycles.
REQ-029 Free-run -> latch_o first high after edge 19, 4 cycles wide, repeats every 16 cycles.
REQ-030 With STRETCH_EN, stall_i high for 5 cycles starting when cnt=6 -> cnt, time_o, latch_o frozen 5 cycles, en_o all 0, then sequence resumes at cnt=7; without macro -> no change vs free-run.
REQ-031 sync_i pulsed with stall_i high at cnt=11 -> all outputs at reset values next cycle, counting restarts from 0.
REQ-032 resb pulsed low asynchronously mid-cycle at cnt=13 -> all outputs 0 immediately; after release, REQ-028 timing reproduced.
